// File: rtl/core_run_ctrl.sv
// core_run_ctrl: resets, gates and counts a core run; ends on TOHOST store or cycle budget.
// Optional single-step gating when RUN_CTRL_STEP_EN is defined.
module core_run_ctrl #(
    parameter int          CNT_W       = 32,
    parameter int          RST_CYCLES  = 4,
    parameter int          MAX_CYCLES  = 1000,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic             instr_done,
    input  logic             step_req,
    output logic             core_rst_n,
    output logic             core_en,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    typedef enum logic [1:0] {HOLD, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic rst_nx, en_nx, done_nx, pass_nx, to_nx, tohost;
    logic [30:0] fc_nx;
    logic [CNT_W-1:0] cyc_nx, ins_nx, cyc_inc, ins_inc;
`ifdef RUN_CTRL_STEP_EN
    localparam logic START_EN = 1'b0;
`else
    localparam logic START_EN = 1'b1;
    logic step_unused;
    assign step_unused = step_req;
`endif
    assign tohost  = mem_we && mem_addr == TOHOST_ADDR;
    assign cyc_inc = &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
    assign ins_inc = &instr_cnt ? instr_cnt : instr_cnt + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= '0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_nx;
            core_rst_n <= rst_nx;
            core_en    <= en_nx;
            done       <= done_nx;
            pass       <= pass_nx;
            timeout    <= to_nx;
            fail_code  <= fc_nx;
            cycle_cnt  <= cyc_nx;
            instr_cnt  <= ins_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        rst_nx   = core_rst_n;
        en_nx    = core_en;
        done_nx  = done;
        pass_nx  = pass;
        to_nx    = timeout;
        fc_nx    = fail_code;
        cyc_nx   = cycle_cnt;
        ins_nx   = instr_cnt;
        case (state)
            HOLD: begin
                if (hold_cnt == HW'(RST_CYCLES - 1)) begin
                    state_nx = RUN;
                    rst_nx   = 1'b1;
                    en_nx    = START_EN;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                cyc_nx = core_en ? cyc_inc : cycle_cnt;
                ins_nx = core_en && instr_done ? ins_inc : instr_cnt;
`ifdef RUN_CTRL_STEP_EN
                en_nx = core_en ? !instr_done : step_req;
`endif
                // A TOHOST store outranks a budget hit in the same cycle.
                if (tohost) begin
                    state_nx = FIN;
                    en_nx    = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = mem_wdata == 32'd1;
                    fc_nx    = mem_wdata == 32'd1 ? 31'd0 : mem_wdata[31:1];
                end else if (core_en && cyc_inc >= CNT_W'(MAX_CYCLES)) begin
                    state_nx = FIN;
                    en_nx    = 1'b0;
                    done_nx  = 1'b1;
                    to_nx    = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed scoreboard bench for core_run_ctrl (RST_CYCLES=4, MAX_CYCLES=50).
module tb_core_run_ctrl;
    localparam int MAXC = 50;
    logic clk = 1'b0, reset = 1'b0, mem_we = 1'b0, instr_done = 1'b0, step_req = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic core_rst_n, core_en, done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_cnt, instr_cnt;
    int n_cmp = 0, n_err = 0;

    typedef struct {
        string       tag;
        logic        p;
        logic        t;
        logic [30:0] fc;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    core_run_ctrl #(.CNT_W(32), .RST_CYCLES(4), .MAX_CYCLES(MAXC), .TOHOST_ADDR(32'h0000_0FFC)) dut (
        .clock(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .instr_done(instr_done), .step_req(step_req), .core_rst_n(core_rst_n), .core_en(core_en),
        .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rstn"}, 32'(core_rst_n), 0);
        chk({tag, "_en"}, 32'(core_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_to"}, 32'(timeout), 0);
        chk({tag, "_fc"}, 32'(fail_code), 0);
        chk({tag, "_cyc"}, cycle_cnt, 0);
        chk({tag, "_ins"}, instr_cnt, 0);
    endtask

    task automatic clear_in();
        mem_we = 1'b0; instr_done = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    // Reset 3 cycles, then 4 hold edges with stray stores/retires that must be ignored.
    task automatic reset_seq();
        reset = 1'b0;
        clear_in();
        repeat (3) tick();
        chk_idle("rst");
        reset = 1'b1;
        mem_we = 1'b1; mem_addr = 32'h0000_0FFC; mem_wdata = 32'd1; instr_done = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("hold%0d_rstn", i), 32'(core_rst_n), 32'(i == 4));
            chk($sformatf("hold%0d_en", i), 32'(core_en), 32'(i == 4));
            chk($sformatf("hold%0d_done", i), 32'(done), 0);
            chk($sformatf("hold%0d_cyc", i), cycle_cnt, 0);
        end
        clear_in();
    endtask

    task automatic run_case(input string tag, input int store_cyc, input logic [31:0] wdata, input int ninstr);
        exp_t e;
        int end_idx;
        bit th;
        th = store_cyc >= 0 && store_cyc <= MAXC - 1;
        end_idx = th ? store_cyc : MAXC - 1;
        e.tag = tag;
        e.p   = th && wdata == 32'd1;
        e.t   = !th;
        e.fc  = th && wdata != 32'd1 ? wdata[31:1] : 31'd0;
        e.cyc = 32'(end_idx + 1);
        e.ins = 32'(ninstr < end_idx + 1 ? ninstr : end_idx + 1);
        sb.push_back(e);
        reset_seq();
        for (int k = 0; k < 200 && !done; k++) begin
            mem_we     = k == store_cyc || k == 2;
            mem_addr   = k == store_cyc ? 32'h0000_0FFC : 32'h0000_0FF8;
            mem_wdata  = wdata;
            instr_done = k < ninstr;
            tick();
        end
        clear_in();
        chk({tag, "_done"}, 32'(done), 1);
        e = sb.pop_front();
        for (int r = 0; r < 2; r++) begin
            string t2;
            t2 = r == 0 ? e.tag : {e.tag, "_frozen"};
            chk({t2, "_pass"}, 32'(pass), 32'(e.p));
            chk({t2, "_to"}, 32'(timeout), 32'(e.t));
            chk({t2, "_fc"}, 32'(fail_code), 32'(e.fc));
            chk({t2, "_cyc"}, cycle_cnt, e.cyc);
            chk({t2, "_ins"}, instr_cnt, e.ins);
            chk({t2, "_en"}, 32'(core_en), 0);
            chk({t2, "_rstn"}, 32'(core_rst_n), 1);
            mem_we = 1'b1; mem_addr = 32'h0000_0FFC; mem_wdata = 32'd5; instr_done = 1'b1;
            repeat (3) tick();
            clear_in();
        end
    endtask

    initial begin
        run_case("pass", 20, 32'd1, 7);
        run_case("fail7", 5, 32'h0000_0007, 3);
        run_case("failhi", 10, 32'hFFFF_FFFE, 4);
        run_case("timeout", -1, 32'd1, 60);
        run_case("simul", MAXC - 1, 32'd1, 0);
        reset_seq();
        instr_done = 1'b1;
        repeat (10) tick();
        clear_in();
        chk("mid_cyc", cycle_cnt, 10);
        chk("mid_ins", instr_cnt, 10);
        reset = 1'b0;
        #1;
        chk_idle("midrst");
        run_case("after_rst", 3, 32'd1, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
